// File: rtl/univ_shiftreg_nbit.sv
// Universal N-bit shift register: hold / shift / load modes plus an
// automatic serialise burst that shifts a loaded word out over WIDTH cycles.
module univ_shiftreg_nbit #(
    parameter int              WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int             CW        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] pi,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic             start,
    input  logic             dir,
    output logic [WIDTH-1:0] po,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] po_q, po_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] shr, shl;

    assign shr = {sin_r, po_q[WIDTH-1:1]};
    assign shl = {po_q[WIDTH-2:0], sin_l};

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
            po_q    <= RESET_VAL;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            po_q    <= po_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        po_d    = po_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    po_d    = pi;
                    dir_d   = dir;
                    cnt_d   = '0;
                    state_d = BURST;
                end else begin
                    unique case (mode)
                        2'b00: po_d = po_q;
                        2'b01: po_d = shr;
                        2'b10: po_d = shl;
                        2'b11: po_d = pi;
                        default: po_d = po_q;
                    endcase
                end
            end
            BURST: begin
                // Direction comes from the value latched at start, not the live input
                po_d  = dir_q ? shl : shr;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign po     = po_q;
    assign sout_r = po_q[0];
    assign sout_l = po_q[WIDTH-1];
    assign busy   = (state_q == BURST);
    assign done   = done_q;
    assign cnt    = cnt_q;

endmodule

// File: tb/tb_univ_shiftreg_nbit.sv
// Scoreboard bench for univ_shiftreg_nbit: stimulus queues cycle-stamped
// expectations, a negedge monitor pops and compares them.
module tb_univ_shiftreg_nbit;

    typedef enum int {K_PO, K_CNT, K_BUSY, K_DONE, K_SR, K_SL} kind_e;

    typedef struct {
        string      name;
        int         cyc;
        int         dut;
        kind_e      kind;
        logic [63:0] val;
    } exp_t;

    exp_t q[$];

    logic clk = 1'b0;
    int   cyc = 0;
    int   nrun = 0;
    int   nfail = 0;
    int   d8 = 0;
    int   d32 = 0;

    // 8-bit instance signals
    logic       clear8 = 1'b1;
    logic [1:0] mode = 2'b00;
    logic [7:0] pi8 = '0;
    logic       sin_r = 1'b0;
    logic       sin_l = 1'b0;
    logic       start8 = 1'b0;
    logic       dir8 = 1'b0;
    logic [7:0] po8;
    logic       sr8, sl8, busy8, done8;
    logic [3:0] cnt8;

    // 32-bit instance signals
    logic        clear32 = 1'b1;
    logic [1:0]  mode32 = 2'b00;
    logic [31:0] pi32 = '0;
    logic        sr_in32 = 1'b0;
    logic        sl_in32 = 1'b0;
    logic        start32 = 1'b0;
    logic        dir32 = 1'b0;
    logic [31:0] po32;
    logic        sr32, sl32, busy32, done32;
    logic [5:0]  cnt32;

    univ_shiftreg_nbit #(.WIDTH(8), .RESET_VAL(8'h00)) dut8 (
        .clk(clk), .clear(clear8), .mode(mode), .pi(pi8),
        .sin_r(sin_r), .sin_l(sin_l), .start(start8), .dir(dir8),
        .po(po8), .sout_r(sr8), .sout_l(sl8),
        .busy(busy8), .done(done8), .cnt(cnt8)
    );

    univ_shiftreg_nbit #(.WIDTH(32), .RESET_VAL(32'h0)) dut32 (
        .clk(clk), .clear(clear32), .mode(mode32), .pi(pi32),
        .sin_r(sr_in32), .sin_l(sl_in32), .start(start32), .dir(dir32),
        .po(po32), .sout_r(sr32), .sout_l(sl32),
        .busy(busy32), .done(done32), .cnt(cnt32)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] actual(int dut, kind_e k);
        logic [63:0] v;
        v = '0;
        if (dut == 8) begin
            case (k)
                K_PO:   v = 64'(po8);
                K_CNT:  v = 64'(cnt8);
                K_BUSY: v = 64'(busy8);
                K_DONE: v = 64'(done8);
                K_SR:   v = 64'(sr8);
                K_SL:   v = 64'(sl8);
                default: v = '0;
            endcase
        end else begin
            case (k)
                K_PO:   v = 64'(po32);
                K_CNT:  v = 64'(cnt32);
                K_BUSY: v = 64'(busy32);
                K_DONE: v = 64'(done32);
                K_SR:   v = 64'(sr32);
                K_SL:   v = 64'(sl32);
                default: v = '0;
            endcase
        end
        return v;
    endfunction

    // Monitor: compare every expectation stamped for the current cycle
    always @(negedge clk) begin
        if (done8) d8++;
        if (done32) d32++;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            logic [63:0] a;
            e = q.pop_front();
            nrun++;
            a = actual(e.dut, e.kind);
            if (e.cyc != cyc) begin
                nfail++;
                $display("FAIL %s: stale expectation cyc %0d at cyc %0d", e.name, e.cyc, cyc);
            end else if (a !== e.val) begin
                nfail++;
                $display("FAIL %s (cyc %0d): got %h expected %h", e.name, cyc, a, e.val);
            end
        end
    end

    task automatic push(string nm, int dut, kind_e k, logic [63:0] v);
        exp_t e;
        e.name = nm;
        e.cyc  = cyc;
        e.dut  = dut;
        e.kind = k;
        e.val  = v;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, int a, int b);
        nrun++;
        if (a != b) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", nm, a, b);
        end
    endtask

    initial begin
        logic [7:0] rseq;
        logic [7:0] lseq;
        int d8_0;

        // Reset state
        step();
        push("rst_po8", 8, K_PO, 64'h00);
        push("rst_cnt8", 8, K_CNT, 64'd0);
        push("rst_busy8", 8, K_BUSY, 64'd0);
        push("rst_done8", 8, K_DONE, 64'd0);
        push("rst_po32", 32, K_PO, 64'h0);
        clear8 = 1'b0;
        clear32 = 1'b0;
        step();

        // Test 1: asynchronous clear mid-burst on the 32-bit instance
        pi32 = 32'hDEADBEEF;
        start32 = 1'b1;
        step();
        start32 = 1'b0;
        push("t1_load", 32, K_PO, 64'hDEADBEEF);
        for (int i = 0; i < 4; i++) step();
        push("t1_cnt4", 32, K_CNT, 64'd4);
        push("t1_busy", 32, K_BUSY, 64'd1);
        step();
        #1;
        clear32 = 1'b1;
        push("t1_clr_po", 32, K_PO, 64'h0);
        push("t1_clr_busy", 32, K_BUSY, 64'd0);
        push("t1_clr_cnt", 32, K_CNT, 64'd0);
        step();
        step();
        clear32 = 1'b0;
        for (int i = 0; i < 40; i++) step();
        push("t1_after_po", 32, K_PO, 64'h0);
        push("t1_after_busy", 32, K_BUSY, 64'd0);
        push("t1_after_cnt", 32, K_CNT, 64'd0);
        step();
        chk("t1_no_done", d32, 0);

        // Test 2: idle modes
        mode = 2'b11;
        pi8 = 8'hA5;
        step();
        push("t2_load", 8, K_PO, 64'hA5);
        mode = 2'b01;
        sin_r = 1'b1;
        step();
        push("t2_shr", 8, K_PO, 64'hD2);
        mode = 2'b10;
        sin_l = 1'b0;
        step();
        push("t2_shl", 8, K_PO, 64'hA4);
        mode = 2'b00;
        for (int i = 0; i < 3; i++) begin
            step();
            push("t2_hold", 8, K_PO, 64'hA4);
        end
        sin_r = 1'b0;

        // Test 3: right burst
        rseq = 8'b1001_1010;
        pi8 = 8'h9A;
        dir8 = 1'b0;
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            push("t3_cnt", 8, K_CNT, 64'(k));
            push("t3_busy", 8, K_BUSY, 64'd1);
            push("t3_sout_r", 8, K_SR, 64'(rseq[k]));
            push("t3_done_lo", 8, K_DONE, 64'd0);
            step();
        end
        push("t3_po", 8, K_PO, 64'h00);
        push("t3_cnt8", 8, K_CNT, 64'd8);
        push("t3_busy_lo", 8, K_BUSY, 64'd0);
        push("t3_done", 8, K_DONE, 64'd1);
        step();
        push("t3_done_clr", 8, K_DONE, 64'd0);
        push("t3_cnt_hold", 8, K_CNT, 64'd8);

        // Test 4: left burst with fill
        lseq = 8'b0000_1111;
        pi8 = 8'hF0;
        dir8 = 1'b1;
        sin_l = 1'b1;
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            push("t4_sout_l", 8, K_SL, 64'(lseq[k]));
            step();
        end
        push("t4_po", 8, K_PO, 64'hFF);
        push("t4_done", 8, K_DONE, 64'd1);
        sin_l = 1'b0;
        step();

        // Test 5: mode/pi/start/dir ignored during a burst
        d8_0 = d8;
        pi8 = 8'h55;
        dir8 = 1'b0;
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        push("t5_load", 8, K_PO, 64'h55);
        step();
        step();
        mode = 2'b11;
        pi8 = 8'h3C;
        dir8 = 1'b1;
        start8 = 1'b1;
        step();
        push("t5_po", 8, K_PO, 64'h0A);
        push("t5_cnt", 8, K_CNT, 64'd3);
        start8 = 1'b0;
        mode = 2'b00;
        dir8 = 1'b0;
        for (int i = 0; i < 5; i++) step();
        push("t5_end_po", 8, K_PO, 64'h00);
        push("t5_end_done", 8, K_DONE, 64'd1);
        step();
        push("t5_idle", 8, K_BUSY, 64'd0);
        step();
        step();
        chk("t5_one_done", d8 - d8_0, 1);

        // Test 6: back-to-back bursts
        pi8 = 8'hC3;
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        for (int i = 0; i < 8; i++) step();
        push("t6_done1", 8, K_DONE, 64'd1);
        push("t6_po1", 8, K_PO, 64'h00);
        pi8 = 8'h81;
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        push("t6_busy", 8, K_BUSY, 64'd1);
        push("t6_done_lo", 8, K_DONE, 64'd0);
        push("t6_cnt0", 8, K_CNT, 64'd0);
        push("t6_po", 8, K_PO, 64'h81);
        for (int i = 0; i < 8; i++) step();
        push("t6_done2", 8, K_DONE, 64'd1);
        push("t6_po2", 8, K_PO, 64'h00);
        push("t6_cnt8", 8, K_CNT, 64'd8);
        step();
        step();

        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", nrun, nfail);
        $finish;
    end

endmodule

// File: doc/univ_shiftreg_nbit.md
Name: univ_shiftreg_nbit

Overview:
Parametrised universal register, the successor to the fixed 32-bit parallel-in/parallel-out register. Adds:
- hold, shift-right, shift-left and parallel-load modes under a mode select;
- serial inputs and outputs;
- an automatic serialise burst: load a word, then shift it out over WIDTH cycles with busy and done status.

It sits between parallel datapath registers and serial links in the DDCO lab designs.

Parameters:
WIDTH, 32, register width in bits; legal range 2 to 64.
RESET_VAL, 0, value loaded into the register on clear (WIDTH bits).

Ports:
clk  input  1  rising-edge clock
clear  input  1  asynchronous, active-high reset
mode  input  2  idle-mode operation: 00 hold, 01 shift right, 10 shift left, 11 parallel load
pi  input  WIDTH  parallel data in
sin_r  input  1  serial fill bit entering the MSB on a right shift
sin_l  input  1  serial fill bit entering the LSB on a left shift
start  input  1  begin a serialise burst; sampled only in IDLE
dir  input  1  burst direction, sampled with start: 0 right (LSB first), 1 left (MSB first)
po  output  WIDTH  register contents
sout_r  output  1  po[0], combinational
sout_l  output  1  po[WIDTH-1], combinational
busy  output  1  high while a burst is shifting
done  output  1  one-cycle pulse when a burst completes
cnt  output  $clog2(WIDTH+1)  shifts completed in the current burst

Behaviour:
- Reset: clear high asynchronously forces the following, and holds them while clear is high. This applies at any time, including mid-burst; the burst is abandoned with no done pulse.
  - po = RESET_VAL
  - state = IDLE
  - busy = 0, done = 0, cnt = 0
  - stored burst direction = 0
- Operating states: IDLE and BURST. All register updates occur on the rising clk edge.
- IDLE, start = 0 (mode applies):
  - 00: po holds.
  - 01: po <= {sin_r, po[WIDTH-1:1]}.
  - 10: po <= {po[WIDTH-2:0], sin_l}.
  - 11: po <= pi.
- IDLE, start = 1 (start overrides mode):
  - po <= pi; latch dir.
  - busy <= 1, cnt <= 0, state <= BURST.
- BURST, each edge:
  - Shift in the latched direction: right uses sin_r as fill, left uses sin_l.
  - cnt <= cnt + 1.
  - mode, start, pi and dir are ignored. A start during BURST is dropped, not queued.
- Burst completion: on the edge where cnt goes from WIDTH-1 to WIDTH:
  - busy <= 0, done <= 1, state <= IDLE.
  - cnt holds WIDTH until the next start or clear.
- done timing:
  - done is high for exactly one cycle and clears on the following edge.
  - A start sampled in that same cycle is accepted (back-to-back bursts), with done still clearing.
- Serial stream: the bit of interest is visible on sout_r (right) or sout_l (left) before each shift edge.
  - Bit k of the loaded word (right) is on sout_r during the cycle where cnt = k, for k = 0 to WIDTH-1.
- Total burst latency: 1 load edge + WIDTH shift edges. busy is high for exactly WIDTH cycles.
- Widths:
  - cnt is sized to hold WIDTH without wrap; it never wraps.
  - po never changes width; shifted-out bits are discarded.
- clear deassertion: the first active edge is the next rising clk, with normal IDLE behaviour.

Test Plan:
1. Reset mid-burst: WIDTH=32, RESET_VAL=0. Start with pi=32'hDEADBEEF, then assert clear asynchronously (between clock edges) after 5 shifts -> po=0, busy=0, cnt=0 immediately, before the next edge; no done pulse follows.
2. Idle modes, WIDTH=8:
   - mode=11, pi=8'hA5 -> po=8'hA5.
   - mode=01, sin_r=1 -> po=8'hD2.
   - mode=10, sin_l=0 -> po=8'hA4.
   - mode=00 for 3 cycles -> po stays 8'hA4.
3. Right burst, WIDTH=8: pi=8'b1001_1010, dir=0, start pulse, sin_r=0 ->
   - sout_r sequence over cnt=0..7 is 0,1,0,1,1,0,0,1;
   - busy high 8 cycles; done high 1 cycle; po=8'h00; cnt=8.
4. Left burst with fill, WIDTH=8: pi=8'hF0, dir=1, sin_l=1 ->
   - sout_l sequence is 1,1,1,1,0,0,0,0;
   - final po=8'hFF.
5. Ignored inputs during burst: during a burst, toggle mode=11 with pi=8'h3C and pulse start again -> po and cnt are unaffected; exactly one done pulse.
6. Back-to-back bursts: start asserted in the done cycle with pi=8'h81 -> new burst begins; busy goes high the next cycle; done low that cycle; cnt=0.
